pixel_plot_sink: RTL

- Receiving end of the sprite pixel stream (x, y, colour) produced by the sprite controllers.
- Accepts pixels over a valid/ready handshake and buffers them in a small FIFO.
- Clips off-screen coordinates and converts x/y to a linear 160x120 framebuffer address.
- Issues single-cycle write strobes to the framebuffer port when that port grants access; also provides a whole-screen fill command used for screen clears.

---
 rtl/pixel_plot_sink.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pixel_plot_sink.sv
// rtl/pixel_plot_sink.sv - sprite pixel sink: FIFO, clipping, framebuffer writes, screen fill
module pixel_plot_sink #(
  parameter int DEPTH    = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [11:0] in_colour,
  output logic        in_ready,
  input  logic        fill_start,
  input  logic [11:0] fill_colour,
  output logic        fill_done,
  input  logic        mem_grant,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [11:0] mem_data,
  output logic [7:0]  drop_count,
  output logic        busy
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [7:0]  W_LIM     = 8'(SCREEN_W);
  localparam logic [6:0]  H_LIM     = 7'(SCREEN_H);
  localparam logic [14:0] LAST_ADDR = 15'(SCREEN_W * SCREEN_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_FILL} state_t;

  state_t        state_q, state_d;
  logic [26:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [14:0]   fill_cnt_q;
  logic [11:0]   fill_col_q;
  logic [7:0]    drop_q;
  logic          mem_we_q, fill_done_q;
  logic [14:0]   mem_addr_q;
  logic [11:0]   mem_data_q;

  logic        full, empty, accept, on_screen, push, clip, pop, fill_wr, fill_req, fill_last;
  logic [14:0] pix_addr;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  // A fill request in IDLE wins over a same-cycle pixel, so ready is withdrawn.
  assign in_ready  = resetn && !full && (state_q == S_IDLE || state_q == S_STREAM)
                     && !(state_q == S_IDLE && fill_start);
  assign accept    = in_valid && in_ready;
  assign on_screen = (in_x < W_LIM) && (in_y < H_LIM);
  assign push      = accept && on_screen;
  assign clip      = accept && !on_screen;
  assign pop       = !empty && mem_grant;
  assign fill_wr   = (state_q == S_FILL) && mem_grant;
  assign fill_last = fill_wr && (fill_cnt_q == LAST_ADDR);
  assign fill_req  = fill_start && (state_q == S_IDLE || state_q == S_STREAM);
  assign pix_addr  = ({8'd0, in_y} << 7) + ({8'd0, in_y} << 5) + {7'd0, in_x};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (fill_start)  state_d = S_FILL;
        else if (push)   state_d = S_STREAM;
      end
      S_STREAM: begin
        if (fill_start)                                state_d = S_DRAIN;
        else if (pop && !push && count_q == (AW+1)'(1)) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (empty || (pop && count_q == (AW+1)'(1)))   state_d = S_FILL;
      end
      S_FILL: begin
        if (fill_last)   state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {pix_addr, in_colour};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fill_cnt_q  <= '0;
      fill_col_q  <= '0;
      drop_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_done_q <= fill_last;
      mem_we_q    <= pop || fill_wr;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (clip && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      if (fill_req) fill_col_q <= fill_colour;
      if (state_q != S_FILL) fill_cnt_q <= '0;
      else if (fill_wr)      fill_cnt_q <= fill_cnt_q + 15'd1;
      if (pop) begin
        {mem_addr_q, mem_data_q} <= fifo_mem[rd_ptr_q];
      end else if (fill_wr) begin
        mem_addr_q <= fill_cnt_q;
        mem_data_q <= fill_col_q;
      end
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign drop_count = drop_q;
  assign fill_done  = fill_done_q;
  assign busy       = (state_q != S_IDLE) || mem_we_q;

endmodule
